uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have exactly one parameter: OVERSAMPLE, default 16, number of baud ticks per serial bit (legal 4..16).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port `clk_i`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port `rst_n_i`, input, 1 bit: synchronous active-low reset.
REQ-005 Port `baud_tick_i`, input, 1 bit: one-cycle pulse from the baud rate generator, arriving at OVERSAMPLE times the bit rate.
REQ-006 Port `tx_data_i`, input, 8 bits: byte to transmit, sent LSB first.
REQ-007 Port `tx_valid_i`, input, 1 bit: a byte is offered on `tx_data_i`.
REQ-008 Port `tx_ready_o`, output, 1 bit: the block can accept a byte this cycle.
REQ-009 Port `data_bits_i`, input, 2 bits: word length is 5 + `data_bits_i` (5..8 bits).
REQ-010 Port `parity_en_i`, input, 1 bit: insert a parity bit after the data bits.
REQ-011 Port `even_parity_i`, input, 1 bit: 1 selects even parity, 0 selects odd parity.
REQ-012 Port `stop_bits_i`, input, 1 bit: 0 sends one stop bit, 1 sends two stop bits.
REQ-013 Port `tx_o`, output, 1 bit: serial line, idle high, driven from a register.
REQ-014 Port `tx_busy_o`, output, 1 bit: high while a frame is in progress.
REQ-015 Port `tx_done_o`, output, 1 bit: one-cycle pulse marking the end of a frame.

Function
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 `tx_ready_o` SHALL be 1 only in IDLE.
- A byte is accepted on any edge where `tx_valid_i` and `tx_ready_o` are both 1.
REQ-018 On acceptance the block SHALL latch `tx_data_i`, `data_bits_i`, `parity_en_i`, `even_parity_i` and `stop_bits_i`.
- Later changes to these inputs SHALL NOT affect the frame in flight.
REQ-019 On acceptance the state SHALL become START, and in the same cycle `tx_o` SHALL be 0 and `tx_busy_o` SHALL be 1.
REQ-020 A 4-bit tick counter SHALL count `baud_tick_i` pulses.
- It is cleared on acceptance and on every bit boundary.
- A bit ends on the tick that brings the count to OVERSAMPLE.
- A tick coincident with acceptance SHALL NOT be counted.
REQ-021 START SHALL drive `tx_o`=0 for one bit, then move to DATA.
REQ-022 DATA SHALL drive data bit i (i = 0..N-1, N = word length) for one bit each, using a 3-bit bit index.
- After bit N-1 the state moves to PARITY if parity is enabled, otherwise to STOP.
REQ-023 PARITY SHALL drive a parity bit over the N data bits only:
- even: XOR of those bits;
- odd: inverted XOR of those bits.
REQ-024 STOP SHALL drive `tx_o`=1 for one bit, or two bits when the latched stop-bit setting is 1.
REQ-025 On the final stop-bit boundary the block SHALL:
- pulse `tx_done_o` for exactly one cycle;
- enter IDLE;
- drop `tx_busy_o` and raise `tx_ready_o` from the next cycle.
REQ-026 Back-to-back frames SHALL be supported: a byte accepted in the first IDLE cycle starts a new start bit immediately, with no extra idle bits.
REQ-027 In IDLE, `tx_o` SHALL be 1, and `baud_tick_i` pulses SHALL be ignored.
REQ-028 If `baud_tick_i` is held 0, the block SHALL hold its current state and current bit indefinitely.
REQ-029 Frame length SHALL be OVERSAMPLE × (1 + N + P + S) ticks, where P = parity enabled (0/1) and S = number of stop bits (1 or 2).

Reset
REQ-030 With `rst_n_i`=0 at an edge, the block SHALL go to IDLE and set:
- `tx_o`=1, `tx_ready_o`=1, `tx_busy_o`=0, `tx_done_o`=0;
- tick counter = 0, bit index = 0, data register = 0.
REQ-031 Reset mid-frame SHALL abort the frame with no `tx_done_o` pulse, and the line SHALL be high on the cycle after the reset edge.

Structure
REQ-032 A shared package `uart_pkg` SHALL hold:
- the state enumeration;
- the OVERSAMPLE default constant (16);
- the word-length base constant (5);
- the constants for the parity and stop-bit encodings.
REQ-033 The block SHALL be a single module with no sub-modules.
- Parity SHALL be computed inline from the latched data, masked to N bits.

Verification
REQ-034 Bench scenario: OVERSAMPLE=16, tick every cycle, 8N1, byte 0x55 -> `tx_o` sequence 0,1,0,1,0,1,0,1,0,1, each bit lasting 16 cycles; `tx_done_o` pulses at cycle 160 after acceptance.
REQ-035 Bench scenario: 7 data bits, even parity, 2 stop bits, byte 0x83 -> data bits 1,1,0,0,0,0,0; parity 0; two high stop bits; 11 bits = 176 ticks.
REQ-036 Bench scenario: 5 data bits, odd parity, byte 0x1F -> data 1,1,1,1,1; parity 0; bits 5-7 of the input ignored.
REQ-037 Bench scenario: `tx_valid_i` held high with bytes 0xA5 then 0x3C -> second start bit immediately follows the first frame's stop bit; no `tx_o` glitch; two `tx_done_o` pulses.
REQ-038 Bench scenario: `rst_n_i` asserted during DATA bit 3 -> next cycle `tx_o`=1 and `tx_ready_o`=1; no `tx_done_o` pulse.
REQ-039 Bench scenario: ticks gated off mid-bit for 100 cycles -> `tx_o` and the state are held, then resume; bit width stays exactly 16 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, framing constants and encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned WORD_BASE      = 5;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;
    localparam logic STOP_ONE    = 1'b0;
    localparam logic STOP_TWO    = 1'b1;

    // Index of the last data bit for a word-length code (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'(WORD_BASE - 1) + 3'(data_bits);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte with framing options and shifts it out LSB first,
// one serial bit per OVERSAMPLE baud ticks.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       baud_tick_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [1:0] data_bits_i,
    input  logic       parity_en_i,
    input  logic       even_parity_i,
    input  logic       stop_bits_i,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    uart_state_e state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  dbits_q, dbits_d;
    logic        par_en_q, par_en_d;
    logic        even_q, even_d;
    logic        stop2_q, stop2_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;

    logic        bit_end_c;
    logic [2:0]  bit_nx_c;
    logic [1:0]  mask_shift_c;
    logic [7:0]  mask_c;
    logic        parity_c;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            dbits_q  <= '0;
            par_en_q <= 1'b0;
            even_q   <= PARITY_ODD;
            stop2_q  <= STOP_ONE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            dbits_q  <= dbits_d;
            par_en_q <= par_en_d;
            even_q   <= even_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Next-state and registered-output logic; every register holds unless a bit boundary or acceptance occurs.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        data_d   = data_q;
        dbits_d  = dbits_q;
        par_en_d = par_en_q;
        even_d   = even_q;
        stop2_d  = stop2_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        done_d   = 1'b0;

        bit_end_c    = baud_tick_i && (tick_q == TICK_LAST);
        bit_nx_c     = bit_q + 3'd1;
        mask_shift_c = 2'd3 - dbits_q;
        mask_c       = 8'hFF >> mask_shift_c;
        parity_c     = (^(data_q & mask_c)) ^ (even_q == PARITY_ODD);

        if (state_q != ST_IDLE && baud_tick_i) begin
            tick_d = bit_end_c ? 4'd0 : tick_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                tick_d  = '0;
                if (tx_valid_i && ready_q) begin
                    data_d   = tx_data_i;
                    dbits_d  = data_bits_i;
                    par_en_d = parity_en_i;
                    even_d   = even_parity_i;
                    stop2_d  = stop_bits_i;
                    state_d  = ST_START;
                    bit_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    if (bit_q == last_bit_idx(dbits_q)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_c;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nx_c;
                        tx_d  = data_q[bit_nx_c];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                // bit_q counts stop bits already sent when two are requested.
                if (bit_end_c) begin
                    if (stop2_q == STOP_TWO && bit_q == 3'd0) begin
                        bit_d = 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign tx_o       = tx_q;
    assign tx_busy_o  = busy_q;
    assign tx_ready_o = ready_q;
    assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected line patterns,
// a tick-counting monitor compares the serial line every cycle.
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       clk;
    logic       rst_n_i;
    logic       baud_tick_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [1:0] data_bits_i;
    logic       parity_en_i;
    logic       even_parity_i;
    logic       stop_bits_i;
    logic       tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .baud_tick_i   (baud_tick_i),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .data_bits_i   (data_bits_i),
        .parity_en_i   (parity_en_i),
        .even_parity_i (even_parity_i),
        .stop_bits_i   (stop_bits_i),
        .tx_o          (tx_o),
        .tx_busy_o     (tx_busy_o),
        .tx_done_o     (tx_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected frame: line bits in time order (bit 0 = start bit) and bit count.
    typedef struct packed {
        logic [11:0] line;
        logic [3:0]  nbits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mode = 0;
    int   tcount = 0;
    int   frames_done = 0;
    int   aborts = 0;
    int   end_cyc = 0;
    int   last_gap = 0;
    int   mon_err0 = 0;
    logic mon_en = 1'b0;
    logic tick_seen = 1'b0;
    logic rst_seen = 1'b0;
    exp_t cur;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        tick_seen <= baud_tick_i;
        rst_seen  <= !rst_n_i;
    end

    // Monitor: mode 0 = idle hunt, 1 = inside frame, 2 = resync after a mismatch.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            case (mode)
                0: begin
                    if (tx_o === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", 32'(exp_q.size()), 32'd1);
                            mode = 2;
                        end else begin
                            cur      = exp_q.pop_front();
                            tcount   = 0;
                            last_gap = cyc - end_cyc;
                            mode     = 1;
                            mon_err0 = errors;
                            check("frame_bit", 32'({tx_ready_o, tx_busy_o, tx_done_o, tx_o}),
                                  32'({3'b010, cur.line[0]}));
                            if (errors != mon_err0) mode = 2;
                        end
                    end else begin
                        check("idle_outputs", 32'({tx_ready_o, tx_busy_o, tx_done_o}), 32'h4);
                    end
                end
                1: begin
                    if (rst_seen) begin
                        check("abort_outputs", 32'({tx_ready_o, tx_busy_o, tx_done_o, tx_o}), 32'h9);
                        aborts++;
                        end_cyc = cyc;
                        mode = 0;
                    end else begin
                        if (tick_seen) tcount++;
                        mon_err0 = errors;
                        if (tcount == int'(cur.nbits) * OS) begin
                            check("frame_end", 32'({tx_ready_o, tx_busy_o, tx_done_o, tx_o}), 32'hB);
                            frames_done++;
                            end_cyc = cyc;
                            mode = 0;
                        end else begin
                            check("frame_bit", 32'({tx_ready_o, tx_busy_o, tx_done_o, tx_o}),
                                  32'({3'b010, cur.line[tcount / OS]}));
                        end
                        if (errors != mon_err0) mode = 2;
                    end
                end
                default: begin
                    if (rst_seen || (tx_busy_o === 1'b0 && tx_o === 1'b1)) mode = 0;
                end
            endcase
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (tx_ready_o !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (tx_ready_o !== 1'b1) check("ready_timeout", 32'(tx_ready_o), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] db, input logic pe,
                        input logic ep, input logic sb, input logic [11:0] line,
                        input logic [3:0] nb);
        wait_ready();
        tx_data_i     = d;
        data_bits_i   = db;
        parity_en_i   = pe;
        even_parity_i = ep;
        stop_bits_i   = sb;
        tx_valid_i    = 1'b1;
        exp_q.push_back({line, nb});
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int w = 0;
        while (frames_done < n && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("frames_done", 32'(frames_done), 32'(n));
    endtask

    initial begin
        rst_n_i       = 1'b0;
        baud_tick_i   = 1'b1;
        tx_valid_i    = 1'b0;
        tx_data_i     = 8'h00;
        data_bits_i   = 2'd3;
        parity_en_i   = 1'b0;
        even_parity_i = 1'b0;
        stop_bits_i   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({tx_o, tx_ready_o, tx_busy_o, tx_done_o}), 32'hC);
        rst_n_i = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // 8N1 0x55: alternating line, done after 160 ticks.
        send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 12'h2AA, 4'd10);
        wait_frames(1);

        // 7E2 0x83; inputs scrambled after acceptance must not matter.
        send(8'h83, 2'd2, 1'b1, 1'b1, 1'b1, 12'h606, 4'd11);
        tx_data_i     = 8'hFF;
        data_bits_i   = 2'd0;
        parity_en_i   = 1'b0;
        even_parity_i = 1'b0;
        stop_bits_i   = 1'b0;
        wait_frames(2);

        // 5O1: upper input bits ignored in data and parity.
        send(8'h1F, 2'd0, 1'b1, 1'b0, 1'b0, 12'h0BE, 4'd8);
        wait_frames(3);
        send(8'hE0, 2'd0, 1'b1, 1'b0, 1'b0, 12'h0C0, 4'd8);
        wait_frames(4);

        // Back-to-back 8N1 with valid held high.
        wait_ready();
        tx_data_i     = 8'hA5;
        data_bits_i   = 2'd3;
        parity_en_i   = 1'b0;
        even_parity_i = 1'b0;
        stop_bits_i   = 1'b0;
        tx_valid_i    = 1'b1;
        exp_q.push_back({12'h34A, 4'd10});
        @(negedge clk);
        tx_data_i = 8'h3C;
        exp_q.push_back({12'h278, 4'd10});
        wait_ready();
        @(negedge clk);
        tx_valid_i = 1'b0;
        wait_frames(6);
        check("b2b_gap", 32'(last_gap), 32'd1);

        // Reset during data bit 3 aborts without done.
        send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 12'h2AA, 4'd10);
        repeat (70) @(negedge clk);
        rst_n_i = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_count", 32'(aborts), 32'd1);
        repeat (200) @(negedge clk);
        check("no_done_after_abort", 32'(frames_done), 32'd6);

        // Ticks gated off mid-bit for 100 cycles.
        send(8'h0F, 2'd3, 1'b0, 1'b0, 1'b0, 12'h21E, 4'd10);
        repeat (40) @(negedge clk);
        baud_tick_i = 1'b0;
        repeat (100) @(negedge clk);
        check("gated_busy", 32'({tx_busy_o, tx_done_o}), 32'h2);
        baud_tick_i = 1'b1;
        wait_frames(7);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
